// File: rtl/heap_sift_stage.sv
`default_nettype none
// ============================================================================
// Module      : heap_sift_stage
// Description : One sift-down stage of a pipelined min-heap sorter. It accepts a
//               {parent slot, value} command and reads both children from the
//               child-level dpram. It then writes the smaller of the value and
//               the smallest existing child into the parent slot. When a child
//               wins, the hole moves down: the stage either forwards
//               {child slot, value} downstream (LAST=0) or writes the value into
//               the leaf slot (LAST=1).
// Ports       : clk, rst_n                      - clock, synchronous active-low reset
//               in_valid/in_ready/in_pos/in_val - upstream command handshake
//               heap_size                       - valid node count, sampled on accept
//               ch_addr_a/b, ch_q_a/b           - child dpram read ports (1-cycle latency)
//               ch_we, ch_data                  - child dpram port a write (LAST=1 only)
//               par_we, par_addr, par_data      - parent dpram write (one-cycle pulse)
//               out_valid/out_ready/out_pos/out_val - downstream command handshake
//               busy                            - stage is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module heap_sift_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LEVEL      = 1,
    parameter int SIZE_WIDTH = 8,
    parameter int LAST       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pos,
    input  logic [DATA_WIDTH-1:0] in_val,
    input  logic [SIZE_WIDTH-1:0] heap_size,
    output logic [ADDR_WIDTH-1:0] ch_addr_a,
    output logic [ADDR_WIDTH-1:0] ch_addr_b,
    input  logic [DATA_WIDTH-1:0] ch_q_a,
    input  logic [DATA_WIDTH-1:0] ch_q_b,
    output logic                  ch_we,
    output logic [DATA_WIDTH-1:0] ch_data,
    output logic                  par_we,
    output logic [ADDR_WIDTH-1:0] par_addr,
    output logic [DATA_WIDTH-1:0] par_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pos,
    output logic [DATA_WIDTH-1:0] out_val,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CMP  = 2'd2,
        S_FWD  = 2'd3
    } state_t;

    // Parent slots wrap modulo the level width.
    localparam logic [ADDR_WIDTH-1:0] POS_MASK = ADDR_WIDTH'((1 << LEVEL) - 1);
    // Global heap index of the first slot in the child level.
    localparam logic [SIZE_WIDTH-1:0] CH_BASE  = SIZE_WIDTH'((1 << (LEVEL + 1)) - 1);
    localparam bit                    IS_LAST  = (LAST != 0);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   p_q, p_d;
    logic [DATA_WIDTH-1:0]   v_q, v_d;
    logic [SIZE_WIDTH-1:0]   size_q, size_d;
    logic [ADDR_WIDTH-1:0]   ch_addr_a_q, ch_addr_a_d;
    logic [ADDR_WIDTH-1:0]   ch_addr_b_q, ch_addr_b_d;
    logic                    ch_we_q, ch_we_d;
    logic [DATA_WIDTH-1:0]   ch_data_q, ch_data_d;
    logic                    par_we_q, par_we_d;
    logic [ADDR_WIDTH-1:0]   par_addr_q, par_addr_d;
    logic [DATA_WIDTH-1:0]   par_data_q, par_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]   out_pos_q, out_pos_d;
    logic [DATA_WIDTH-1:0]   out_val_q, out_val_d;

    // Accept-side slot computation.
    logic [ADDR_WIDTH-1:0]   pos_m;
    assign pos_m = in_pos & POS_MASK;

    // Child existence, evaluated against the heap size latched on accept.
    logic [SIZE_WIDTH-1:0]   gidx_l, gidx_r;
    logic                    has_l, has_r, has_child;
    logic [ADDR_WIDTH-1:0]   slot_l, slot_r, slot_m;
    logic                    pick_r, move;
    logic [DATA_WIDTH-1:0]   m_val;

    assign gidx_l    = CH_BASE + SIZE_WIDTH'({p_q, 1'b0});
    assign gidx_r    = gidx_l + SIZE_WIDTH'(1);
    assign has_l     = (gidx_l < size_q);
    assign has_r     = (gidx_r < size_q);
    assign has_child = has_l | has_r;
    assign slot_l    = {p_q[ADDR_WIDTH-2:0], 1'b0};
    assign slot_r    = {p_q[ADDR_WIDTH-2:0], 1'b1};
    // Right wins only when strictly smaller, so ties go to the left child.
    assign pick_r    = has_r & (~has_l | (ch_q_b < ch_q_a));
    assign m_val     = pick_r ? ch_q_b : ch_q_a;
    assign slot_m    = pick_r ? slot_r : slot_l;
    assign move      = has_child & (v_q > m_val);

    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        v_d         = v_q;
        size_d      = size_q;
        ch_addr_a_d = ch_addr_a_q;
        ch_addr_b_d = ch_addr_b_q;
        ch_we_d     = 1'b0;
        ch_data_d   = ch_data_q;
        par_we_d    = 1'b0;
        par_addr_d  = par_addr_q;
        par_data_d  = par_data_q;
        out_valid_d = out_valid_q;
        out_pos_d   = out_pos_q;
        out_val_d   = out_val_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    p_d         = pos_m;
                    v_d         = in_val;
                    size_d      = heap_size;
                    // Child read addresses are registered here so the dpram
                    // sees them for the whole S_RD cycle.
                    ch_addr_a_d = {pos_m[ADDR_WIDTH-2:0], 1'b0};
                    ch_addr_b_d = {pos_m[ADDR_WIDTH-2:0], 1'b1};
                    state_d     = S_RD;
                end
            end
            S_RD: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                par_we_d   = 1'b1;
                par_addr_d = p_q;
                if (!move) begin
                    par_data_d = v_q;
                    state_d    = S_IDLE;
                end else begin
                    par_data_d = m_val;
                    if (IS_LAST) begin
                        ch_we_d     = 1'b1;
                        ch_addr_a_d = slot_m;
                        ch_data_d   = v_q;
                        state_d     = S_IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                        out_pos_d   = slot_m;
                        out_val_d   = v_q;
                        state_d     = S_FWD;
                    end
                end
            end
            S_FWD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            p_q         <= '0;
            v_q         <= '0;
            size_q      <= '0;
            ch_addr_a_q <= '0;
            ch_addr_b_q <= '0;
            ch_we_q     <= 1'b0;
            ch_data_q   <= '0;
            par_we_q    <= 1'b0;
            par_addr_q  <= '0;
            par_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_pos_q   <= '0;
            out_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            v_q         <= v_d;
            size_q      <= size_d;
            ch_addr_a_q <= ch_addr_a_d;
            ch_addr_b_q <= ch_addr_b_d;
            ch_we_q     <= ch_we_d;
            ch_data_q   <= ch_data_d;
            par_we_q    <= par_we_d;
            par_addr_q  <= par_addr_d;
            par_data_q  <= par_data_d;
            out_valid_q <= out_valid_d;
            out_pos_q   <= out_pos_d;
            out_val_q   <= out_val_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign ch_addr_a = ch_addr_a_q;
    assign ch_addr_b = ch_addr_b_q;
    assign ch_we     = ch_we_q;
    assign ch_data   = ch_data_q;
    assign par_we    = par_we_q;
    assign par_addr  = par_addr_q;
    assign par_data  = par_data_q;
    assign out_valid = out_valid_q;
    assign out_pos   = out_pos_q;
    assign out_val   = out_val_q;

endmodule
`default_nettype wire

// File: tb/tb_heap_sift_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_heap_sift_stage
// Description : Bench for heap_sift_stage. Two instances (LEVEL=1, LAST=0 and
//               LAST=1) share command inputs. Each instance is served by a
//               1-cycle-latency child memory model. Expected parent writes,
//               forwards and leaf writes are queued at command time and
//               compared when the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heap_sift_stage;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } ev_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid0, in_valid1;
    logic [4:0]  in_pos;
    logic [31:0] in_val;
    logic [7:0]  heap_size;
    logic        out_ready;

    logic        in_ready0, ch_we0, par_we0, out_valid0, busy0;
    logic [4:0]  ch_addr_a0, ch_addr_b0, par_addr0, out_pos0;
    logic [31:0] ch_q_a0, ch_q_b0, ch_data0, par_data0, out_val0;
    logic        in_ready1, ch_we1, par_we1, out_valid1, busy1;
    logic [4:0]  ch_addr_a1, ch_addr_b1, par_addr1, out_pos1;
    logic [31:0] ch_q_a1, ch_q_b1, ch_data1, par_data1, out_val1;

    logic [31:0] mem0 [0:31];
    logic [31:0] mem1 [0:31];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ev_t par_q0[$];
    ev_t par_q1[$];
    ev_t fwd_q0[$];
    ev_t chw_q1[$];
    ev_t e0, e1;

    heap_sift_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(1), .SIZE_WIDTH(8), .LAST(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_pos(in_pos), .in_val(in_val),
        .heap_size(heap_size),
        .ch_addr_a(ch_addr_a0), .ch_addr_b(ch_addr_b0), .ch_q_a(ch_q_a0), .ch_q_b(ch_q_b0),
        .ch_we(ch_we0), .ch_data(ch_data0),
        .par_we(par_we0), .par_addr(par_addr0), .par_data(par_data0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_pos(out_pos0), .out_val(out_val0),
        .busy(busy0)
    );

    heap_sift_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LEVEL(1), .SIZE_WIDTH(8), .LAST(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_pos(in_pos), .in_val(in_val),
        .heap_size(heap_size),
        .ch_addr_a(ch_addr_a1), .ch_addr_b(ch_addr_b1), .ch_q_a(ch_q_a1), .ch_q_b(ch_q_b1),
        .ch_we(ch_we1), .ch_data(ch_data1),
        .par_we(par_we1), .par_addr(par_addr1), .par_data(par_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pos(out_pos1), .out_val(out_val1),
        .busy(busy1)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ch_q_a0 <= mem0[ch_addr_a0];
        ch_q_b0 <= mem0[ch_addr_b0];
        ch_q_a1 <= mem1[ch_addr_a1];
        ch_q_b1 <= mem1[ch_addr_b1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (par_we0) begin
            chk("par0_expected", par_q0.size() != 0, 1);
            if (par_q0.size() != 0) begin
                e0 = par_q0.pop_front();
                chk("par0_addr", par_addr0, e0.a);
                chk("par0_data", par_data0, e0.d);
                chk("par0_cycle", cyc, e0.c);
            end
        end
        if (out_valid0) begin
            chk("fwd0_expected", fwd_q0.size() != 0, 1);
            if (fwd_q0.size() != 0) begin
                chk("fwd0_pos", out_pos0, fwd_q0[0].a);
                chk("fwd0_val", out_val0, fwd_q0[0].d);
                if (out_ready) void'(fwd_q0.pop_front());
            end
        end
        if (ch_we0) chk("ch_we0_unused", ch_we0, 0);
        if (par_we1) begin
            chk("par1_expected", par_q1.size() != 0, 1);
            if (par_q1.size() != 0) begin
                e1 = par_q1.pop_front();
                chk("par1_addr", par_addr1, e1.a);
                chk("par1_data", par_data1, e1.d);
                chk("par1_cycle", cyc, e1.c);
            end
        end
        if (ch_we1) begin
            chk("chw1_expected", chw_q1.size() != 0, 1);
            chk("chw1_with_par", par_we1, 1);
            if (chw_q1.size() != 0) begin
                e1 = chw_q1.pop_front();
                chk("chw1_addr", ch_addr_a1, e1.a);
                chk("chw1_data", ch_data1, e1.d);
                chk("chw1_cycle", cyc, e1.c);
            end
        end
        if (out_valid1) chk("out_valid1_never", out_valid1, 0);
    end

    // Drive one command to instance d and, if push is set, queue its results.
    task automatic send(input int d, input logic [4:0] pos, input logic [31:0] val,
                        input logic [7:0] size, input bit push,
                        input logic [4:0] epa, input logic [31:0] epd,
                        input bit mv, input logic [4:0] eslot, output int acc);
        int  n;
        ev_t e;
        in_pos    = pos;
        in_val    = val;
        heap_size = size;
        if (d == 0) in_valid0 = 1'b1; else in_valid1 = 1'b1;
        n = 0;
        while ((((d == 0) ? in_ready0 : in_ready1) !== 1'b1) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", n < 20, 1);
        @(posedge clk); #1;
        acc       = cyc;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        if (push) begin
            e.a = epa; e.d = epd; e.c = acc + 2;
            if (d == 0) par_q0.push_back(e); else par_q1.push_back(e);
            if (mv) begin
                e.a = eslot; e.d = val;
                if (d == 0) fwd_q0.push_back(e); else chw_q1.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 !== 1'b0 || busy1 !== 1'b0) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", n < 30, 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int a, a2;
        rst_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0;
        in_pos = '0; in_val = '0; heap_size = '0; out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin mem0[i] = 32'hFFFF_FFFF; mem1[i] = 32'hFFFF_FFFF; end
        mem0[0] = 5; mem0[1] = 9; mem0[2] = 4; mem0[3] = 4;
        mem1[0] = 2; mem1[1] = 6; mem1[2] = 7; mem1[3] = 3;

        repeat (3) @(posedge clk); #1;
        chk("rst_in_ready0", in_ready0, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_par_we0", par_we0, 0);
        chk("rst_out_valid0", out_valid0, 0);
        chk("rst_ch_addr_a0", ch_addr_a0, 0);
        chk("rst_par_data0", par_data0, 0);
        chk("rst_out_pos0", out_pos0, 0);
        chk("rst_ch_data0", ch_data0, 0);
        chk("rst_ch_we1", ch_we1, 0);
        chk("rst_ch_data1", ch_data1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_out_val1", out_val1, 0);
        chk("rst_out_pos1", out_pos1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // v below both children: stays in parent.
        send(0, 0, 3, 7, 1, 0, 3, 0, 0, a); wait_idle();
        // v equal to the smaller child: no move.
        send(0, 0, 5, 7, 1, 0, 5, 0, 0, a); wait_idle();

        // Left child wins; forward held while out_ready is low.
        out_ready = 1'b0;
        send(0, 0, 7, 7, 1, 0, 5, 1, 0, a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("hold_valid", out_valid0, 1);
            chk("hold_pos", out_pos0, 0);
            chk("hold_val", out_val0, 7);
            chk("hold_busy", busy0, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid_drop", out_valid0, 0);
        chk("hs_in_ready", in_ready0, 1);
        wait_idle();

        // Tie goes left.
        send(0, 1, 8, 7, 1, 1, 4, 1, 2, a); wait_idle();
        // Right child smaller.
        mem0[0] = 9; mem0[1] = 5;
        send(0, 0, 7, 7, 1, 0, 5, 1, 1, a); wait_idle();
        // heap_size=4: children of p=1 (global 5,6) missing.
        send(0, 1, 8, 4, 1, 1, 8, 0, 0, a); wait_idle();
        // heap_size=6: only the left child exists, right would otherwise win.
        mem0[2] = 4; mem0[3] = 1;
        send(0, 1, 8, 6, 1, 1, 4, 1, 2, a); wait_idle();
        // in_pos=3 wraps to p=1; right child (slot 3) wins.
        send(0, 3, 8, 7, 1, 1, 1, 1, 3, a); wait_idle();

        // LAST=1: leaf write coincident with parent write.
        send(1, 0, 9, 7, 1, 0, 2, 1, 0, a); wait_idle();
        send(1, 1, 9, 7, 1, 1, 3, 1, 3, a); wait_idle();
        // Back-to-back: second command accepted in the par_we cycle.
        send(1, 0, 1, 7, 1, 0, 1, 0, 0, a);
        send(1, 1, 2, 7, 1, 1, 2, 0, 0, a2);
        chk("b2b_gap", a2 - a, 3);
        wait_idle();

        // Reset while in S_CMP: command dropped, no write.
        send(0, 0, 7, 7, 0, 0, 0, 0, 0, a);
        @(posedge clk); #1;
        chk("cmp_busy", busy0, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rcmp_par_we", par_we0, 0);
        chk("rcmp_out_valid", out_valid0, 0);
        chk("rcmp_in_ready", in_ready0, 1);
        chk("rcmp_busy", busy0, 0);
        repeat (4) begin @(posedge clk); #1; end

        // Reset while in S_FWD: forward dropped.
        mem0[0] = 5; mem0[1] = 9;
        out_ready = 1'b0;
        send(0, 0, 7, 7, 1, 0, 5, 1, 0, a);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fwd_valid", out_valid0, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        fwd_q0.delete();
        chk("rfwd_out_valid", out_valid0, 0);
        chk("rfwd_par_we", par_we0, 0);
        chk("rfwd_in_ready", in_ready0, 1);
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end

        // Stage still works after the reset.
        send(0, 1, 0, 7, 1, 1, 0, 0, 0, a); wait_idle();

        repeat (3) begin @(posedge clk); #1; end
        chk("par_q0_drained", par_q0.size(), 0);
        chk("par_q1_drained", par_q1.size(), 0);
        chk("fwd_q0_drained", fwd_q0.size(), 0);
        chk("chw_q1_drained", chw_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
